// File: rtl/cic_frame_sequencer.sv
// Gathers one decimated sample per CIC channel and streams them out as an ordered
// frame (ch 0..n_ch-1) on a valid/ready port, with a sticky flag for overwritten samples.
module cic_frame_sequencer #(
    parameter int n_ch = 8,
    parameter int odw  = 15,
    parameter int fcw  = 16,
    localparam int cw  = $clog2(n_ch)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [n_ch-1:0]         ch_dv,
    input  logic [n_ch*odw-1:0]     ch_data,
    output logic signed [odw-1:0]   m_data,
    output logic [cw-1:0]           m_ch,
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic                    m_last,
    output logic                    ovf,
    input  logic                    ovf_clr,
    output logic [fcw-1:0]          frame_cnt,
    output logic [1:0]              dbg_state
);

    // Output handshake: a word transfers on a rising clk edge where m_valid && m_ready;
    // while m_valid is high and m_ready low, m_data/m_ch/m_last hold their values.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1
    } state_t;

    localparam logic [cw-1:0] last_ch = cw'(n_ch - 1);

    state_t                 state_q, state_d;
    logic [cw-1:0]          ptr_q, ptr_d;
    logic [n_ch-1:0]        pend_q, pend_d;
    logic signed [odw-1:0]  hold_q [n_ch];
    logic signed [odw-1:0]  hold_d [n_ch];
    logic signed [odw-1:0]  buf_q  [n_ch];
    logic signed [odw-1:0]  buf_d  [n_ch];
    logic                   ovf_q, ovf_d;
    logic [fcw-1:0]         frame_cnt_q, frame_cnt_d;
    logic                   m_valid_q, m_valid_d;
    logic                   m_last_q, m_last_d;
    logic [cw-1:0]          m_ch_q, m_ch_d;
    logic signed [odw-1:0]  m_data_q, m_data_d;

    logic                   snap;
    logic                   ovf_set;
    logic [cw-1:0]          ptr_inc;

    always_comb begin
        snap        = (state_q == IDLE) && enable && (&pend_q);
        ovf_set     = enable && !snap && (|(ch_dv & pend_q));
        ptr_inc     = ptr_q + cw'(1);

        state_d     = state_q;
        ptr_d       = ptr_q;
        frame_cnt_d = frame_cnt_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_ch_d      = m_ch_q;
        m_data_d    = m_data_q;
        for (int i = 0; i < n_ch; i++) begin
            hold_d[i] = hold_q[i];
            buf_d[i]  = buf_q[i];
            if (enable && ch_dv[i]) begin
                hold_d[i] = ch_data[i*odw +: odw];
            end
        end

        // At a snapshot the pend bits restart from this cycle's strobes so a
        // coincident sample seeds the next frame instead of counting as overrun.
        if (!enable) begin
            pend_d = '0;
        end else if (snap) begin
            pend_d = ch_dv;
        end else begin
            pend_d = pend_q | ch_dv;
        end

        if (ovf_set) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        case (state_q)
            IDLE: begin
                if (snap) begin
                    for (int i = 0; i < n_ch; i++) begin
                        buf_d[i] = hold_q[i];
                    end
                    state_d   = SEND;
                    ptr_d     = '0;
                    m_valid_d = 1'b1;
                    m_data_d  = hold_q[0];
                    m_ch_d    = '0;
                    m_last_d  = 1'b0;
                end
            end
            SEND: begin
                if (m_valid_q && m_ready) begin
                    if (ptr_q == last_ch) begin
                        state_d     = IDLE;
                        ptr_d       = '0;
                        m_valid_d   = 1'b0;
                        m_last_d    = 1'b0;
                        m_ch_d      = '0;
                        frame_cnt_d = frame_cnt_q + fcw'(1);
                    end else begin
                        ptr_d    = ptr_inc;
                        m_data_d = buf_q[ptr_inc];
                        m_ch_d   = ptr_inc;
                        m_last_d = (ptr_inc == last_ch);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            pend_q      <= '0;
            ovf_q       <= 1'b0;
            frame_cnt_q <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_ch_q      <= '0;
            m_data_q    <= '0;
            for (int i = 0; i < n_ch; i++) begin
                hold_q[i] <= '0;
                buf_q[i]  <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            pend_q      <= pend_d;
            ovf_q       <= ovf_d;
            frame_cnt_q <= frame_cnt_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_ch_q      <= m_ch_d;
            m_data_q    <= m_data_d;
            for (int i = 0; i < n_ch; i++) begin
                hold_q[i] <= hold_d[i];
                buf_q[i]  <= buf_d[i];
            end
        end
    end

    assign m_data    = m_data_q;
    assign m_ch      = m_ch_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign ovf       = ovf_q;
    assign frame_cnt = frame_cnt_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_cic_frame_sequencer.sv
// Directed bench for cic_frame_sequencer: expected frame words are queued when strobes
// are driven and checked against every presented/accepted output word.
module tb_cic_frame_sequencer;

    localparam int N_CH = 8;
    localparam int ODW  = 15;
    localparam int FCW  = 16;
    localparam int CW   = 3;
    localparam int EW   = ODW + CW + 1;

    logic                  clk;
    logic                  reset_n;
    logic                  enable;
    logic [N_CH-1:0]       ch_dv;
    logic [N_CH*ODW-1:0]   ch_data;
    logic signed [ODW-1:0] m_data;
    logic [CW-1:0]         m_ch;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic                  ovf;
    logic                  ovf_clr;
    logic [FCW-1:0]        frame_cnt;
    logic [1:0]            dbg_state;

    logic [EW-1:0] exp_q[$];
    int vectors;
    int miscompares;
    int accepts;

    cic_frame_sequencer #(.n_ch(N_CH), .odw(ODW), .fcw(FCW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .enable    (enable),
        .ch_dv     (ch_dv),
        .ch_data   (ch_data),
        .m_data    (m_data),
        .m_ch      (m_ch),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .frame_cnt (frame_cnt),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: look at the output on the falling edge, then step past the rising edge.
    task automatic tick();
        @(negedge clk);
        if (m_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(m_valid), 32'd0);
            end else begin
                check("word", 32'({m_last, m_ch, m_data}), 32'(exp_q[0]));
                if (m_ready) begin
                    void'(exp_q.pop_front());
                    accepts++;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int base);
        for (int i = 0; i < N_CH; i++) begin
            ch_data[i*ODW +: ODW] = ODW'(base + i);
        end
    endtask

    task automatic strobe(input logic [N_CH-1:0] mask);
        ch_dv = mask;
        tick();
        ch_dv = '0;
    endtask

    task automatic push_frame(input int base, input int ovr_idx, input int ovr_val);
        logic [ODW-1:0] d;
        for (int i = 0; i < N_CH; i++) begin
            d = (i == ovr_idx) ? ODW'(ovr_val) : ODW'(base + i);
            exp_q.push_back({(i == N_CH - 1), CW'(i), d});
        end
    endtask

    task automatic drain(input logic [3:0] pat, input int budget);
        int k;
        k = 0;
        while (k < budget && !(exp_q.size() == 0 && !m_valid)) begin
            m_ready = pat[k % 4];
            tick();
            k++;
        end
        m_ready = 1'b1;
        check("drain_done", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        accepts     = 0;
        reset_n     = 1'b0;
        enable      = 1'b0;
        ch_dv       = '0;
        ch_data     = '0;
        m_ready     = 1'b0;
        ovf_clr     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_m_last", 32'(m_last), 32'd0);
        check("rst_m_ch", 32'(m_ch), 32'd0);
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        reset_n = 1'b1;
        tick();

        // Basic frame with latency check.
        enable  = 1'b1;
        m_ready = 1'b1;
        accepts = 0;
        set_data(100);
        push_frame(100, -1, 0);
        strobe('1);
        check("basic_lat1_valid", 32'(m_valid), 32'd0);
        tick();
        check("basic_lat2_valid", 32'(m_valid), 32'd1);
        drain(4'b1111, 40);
        check("basic_accepts", 32'(accepts), 32'd8);
        check("basic_frame_cnt", 32'(frame_cnt), 32'd1);
        check("basic_ovf", 32'(ovf), 32'd0);

        // Backpressure, ready pattern 1,0,0,1.
        accepts = 0;
        push_frame(100, -1, 0);
        strobe('1);
        tick();
        drain(4'b1001, 80);
        check("bp_accepts", 32'(accepts), 32'd8);
        check("bp_frame_cnt", 32'(frame_cnt), 32'd2);

        // Staggered strobes: low half at cycle 0, high half at cycle 5.
        set_data(200);
        push_frame(200, -1, 0);
        strobe(8'h0F);
        for (int c = 1; c < 5; c++) begin
            tick();
            check("stag_no_valid", 32'(m_valid), 32'd0);
        end
        strobe(8'hF0);
        check("stag_c5_valid", 32'(m_valid), 32'd0);
        tick();
        check("stag_c6_valid", 32'(m_valid), 32'd1);
        drain(4'b1111, 40);
        check("stag_frame_cnt", 32'(frame_cnt), 32'd3);

        // Overrun on channel 3: newest sample wins.
        set_data(300);
        ch_data[3*ODW +: ODW] = ODW'(-5);
        strobe(8'h08);
        check("ovr_first_ovf", 32'(ovf), 32'd0);
        ch_data[3*ODW +: ODW] = ODW'(9);
        strobe(8'h08);
        check("ovr_set_ovf", 32'(ovf), 32'd1);
        ch_data[3*ODW +: ODW] = ODW'(1234);
        push_frame(300, 3, 9);
        strobe(8'hF7);
        tick();
        drain(4'b1111, 40);
        check("ovr_frame_cnt", 32'(frame_cnt), 32'd4);
        check("ovr_sticky", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovr_clr", 32'(ovf), 32'd0);
        strobe(8'h01);
        check("ovr_single_no_ovf", 32'(ovf), 32'd0);
        ovf_clr = 1'b1;
        strobe(8'h01);
        ovf_clr = 1'b0;
        check("ovr_set_beats_clr", 32'(ovf), 32'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        check("ovr_clr2", 32'(ovf), 32'd0);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();

        // Coincident strobe in the snapshot cycle.
        m_ready = 1'b0;
        set_data(400);
        push_frame(400, -1, 0);
        strobe('1);
        tick();
        check("coin_a_valid", 32'(m_valid), 32'd1);
        set_data(500);
        push_frame(500, -1, 0);
        strobe('1);
        tick();
        check("coin_send_ovf", 32'(ovf), 32'd0);
        m_ready = 1'b1;
        for (int k = 0; k < 40 && exp_q.size() > N_CH; k++) begin
            tick();
        end
        check("coin_a_drained", 32'(exp_q.size()), 32'(N_CH));
        check("coin_idle_gap", 32'(m_valid), 32'd0);
        ch_data[0 +: ODW] = ODW'(600);
        strobe(8'h01);
        check("coin_b_valid", 32'(m_valid), 32'd1);
        check("coin_ovf", 32'(ovf), 32'd0);
        drain(4'b1111, 40);
        check("coin_frame_cnt", 32'(frame_cnt), 32'd6);
        set_data(700);
        ch_data[0 +: ODW] = ODW'(777);
        push_frame(700, 0, 600);
        strobe(8'hFE);
        tick();
        drain(4'b1111, 40);
        check("coin_c_frame_cnt", 32'(frame_cnt), 32'd7);
        check("coin_c_ovf", 32'(ovf), 32'd0);

        // Asynchronous reset at word 4.
        set_data(800);
        push_frame(800, -1, 0);
        strobe('1);
        for (int k = 0; k < 40 && exp_q.size() > 4; k++) begin
            tick();
        end
        check("rstmid_at_word4", 32'(m_ch), 32'd4);
        reset_n = 1'b0;
        #1;
        check("rstmid_m_valid", 32'(m_valid), 32'd0);
        check("rstmid_m_last", 32'(m_last), 32'd0);
        check("rstmid_frame_cnt", 32'(frame_cnt), 32'd0);
        exp_q.delete();
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check("rstmid_quiet", 32'(m_valid), 32'd0);

        // Enable dropped mid-frame.
        enable = 1'b1;
        set_data(900);
        push_frame(900, -1, 0);
        strobe('1);
        tick();
        tick();
        tick();
        enable = 1'b0;
        drain(4'b1111, 40);
        check("en_frame_cnt", 32'(frame_cnt), 32'd1);
        strobe('1);
        repeat (4) tick();
        check("en_off_no_valid", 32'(m_valid), 32'd0);
        enable = 1'b1;
        repeat (3) tick();
        check("en_on_no_valid", 32'(m_valid), 32'd0);
        check("en_final_cnt", 32'(frame_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
